// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Purpose:
//   Shares one uart_tx transmitter between numReq byte producers. Requests are
//   served round-robin. Each frame is sequenced as IDLE -> SEND -> WAIT_DONE ->
//   GAP -> IDLE. SEND issues a one-cycle start pulse together with the grant.
//   WAIT_DONE blocks until uart_tx reports the frame finished. GAP adds one
//   guaranteed idle cycle between frames.
//
// Parameters:
//   numReq      number of requesters (2..8)
//   timeoutClks WAIT_DONE watchdog length in cycles (only with the macro below)
//
// Optional feature:
//   UART_ARB_TIMEOUT_EN  when defined, a watchdog aborts WAIT_DONE after
//                        timeoutClks cycles without i_txDone and pulses
//                        o_timeout. When undefined, WAIT_DONE waits forever and
//                        o_timeout is tied low.
//
// Ports:
//   i_clk      in   system clock, rising edge
//   i_rst      in   synchronous active-high reset
//   i_req      in   [numReq]    per-requester request level
//   i_data     in   [8*numReq]  byte of requester k at [8k+7:8k]
//   o_grant    out  [numReq]    one-hot 1-cycle pulse: byte accepted
//   o_txStart  out  1-cycle pulse to uart_tx: load o_txData and send
//   o_txData   out  [8]         byte for uart_tx, held until next grant
//   i_txDone   in   1-cycle pulse from uart_tx: frame finished
//   o_busy     out  high from SEND through GAP
//   o_timeout  out  1-cycle pulse on watchdog abort
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int numReq      = 4,
    parameter int timeoutClks = 4096
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [numReq-1:0]     i_req,
    input  logic [8*numReq-1:0]   i_data,
    output logic [numReq-1:0]     o_grant,
    output logic                  o_txStart,
    output logic [7:0]            o_txData,
    input  logic                  i_txDone,
    output logic                  o_busy,
    output logic                  o_timeout
);

    localparam int IDX_W = $clog2(numReq);
    // One extra bit so rrPtr + offset never overflows before the explicit wrap.
    localparam int SUM_W = IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t             stateReg;
    logic [IDX_W-1:0]   rrPtr;
    logic [IDX_W-1:0]   winnerReg;
    logic [IDX_W-1:0]   winnerNext;
    logic               winnerFound;
    logic [numReq-1:0]  grantNext;
    logic [IDX_W-1:0]   candIdx [numReq];

    // candIdx[k] is the requester index visited k-th in the round-robin search,
    // i.e. rrPtr + k wrapped explicitly back to 0 past numReq-1.
    generate
        for (genvar gi = 0; gi < numReq; gi++) begin : g_cand
            logic [SUM_W-1:0] candSum;
            logic [SUM_W-1:0] candWrap;
            assign candSum  = {1'b0, rrPtr} + SUM_W'(gi);
            assign candWrap = (candSum >= SUM_W'(numReq)) ? (candSum - SUM_W'(numReq))
                                                          : candSum;
            assign candIdx[gi] = candWrap[IDX_W-1:0];
        end
    endgenerate

    // Walk the search order from the far end so the nearest pending requester
    // (smallest offset from rrPtr) is the last one written and therefore wins.
    always_comb begin
        winnerFound = 1'b0;
        winnerNext  = '0;
        for (int i = numReq - 1; i >= 0; i--) begin
            if (i_req[candIdx[i]]) begin
                winnerFound = 1'b1;
                winnerNext  = candIdx[i];
            end
        end
    end

    always_comb begin
        grantNext             = '0;
        grantNext[winnerNext] = 1'b1;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(timeoutClks + 1);
    logic [TMR_W-1:0] waitCnt;
`else
    // timeoutClks only matters when the watchdog is built in.
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (timeoutClks != 0);
    assign o_timeout        = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stateReg  <= IDLE;
            rrPtr     <= '0;
            winnerReg <= '0;
            o_grant   <= '0;
            o_txStart <= 1'b0;
            o_txData  <= '0;
            o_busy    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            waitCnt   <= '0;
            o_timeout <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; set only on the cycle that needs them.
            o_txStart <= 1'b0;
            o_grant   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
            o_timeout <= 1'b0;
`endif
            case (stateReg)
                IDLE: begin
                    // Outputs are registered, so the SEND-cycle values are
                    // loaded here; requesters hold i_data stable until grant.
                    if (winnerFound) begin
                        winnerReg <= winnerNext;
                        o_txStart <= 1'b1;
                        o_grant   <= grantNext;
                        o_txData  <= i_data[{winnerNext, 3'b000} +: 8];
                        o_busy    <= 1'b1;
                        stateReg  <= SEND;
                    end
                end

                SEND: begin
                    // Next search starts just past the winner, wrapped by hand.
                    rrPtr    <= (winnerReg == IDX_W'(numReq - 1)) ? '0
                                                                  : winnerReg + 1'b1;
`ifdef UART_ARB_TIMEOUT_EN
                    waitCnt  <= '0;
`endif
                    stateReg <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (i_txDone) begin
                        stateReg <= GAP;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (waitCnt == TMR_W'(timeoutClks - 1)) begin
                        // Abort straight to IDLE; the lost byte is not retried.
                        o_timeout <= 1'b1;
                        o_busy    <= 1'b0;
                        stateReg  <= IDLE;
                    end else begin
                        waitCnt   <= waitCnt + 1'b1;
`endif
                    end
                end

                GAP: begin
                    o_busy   <= 1'b0;
                    stateReg <= IDLE;
                end

                default: stateReg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter (numReq=4, timeoutClks=16). Stimulus
// pushes the expected grant index and byte into a scoreboard queue; a monitor
// pops and compares on every o_txStart. A simple uart_tx model answers each
// start with i_txDone ten cycles later when auto mode is on.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int DONE_DLY = 10;

    logic                   i_clk = 1'b0;
    logic                   i_rst;
    logic [NUM_REQ-1:0]     i_req;
    logic [8*NUM_REQ-1:0]   i_data;
    logic [NUM_REQ-1:0]     o_grant;
    logic                   o_txStart;
    logic [7:0]             o_txData;
    logic                   i_txDone;
    logic                   o_busy;
    logic                   o_timeout;

    logic doneAuto   = 1'b0;
    logic doneManual = 1'b0;
    assign i_txDone = doneAuto | doneManual;

    always #5 i_clk = ~i_clk;

    uart_tx_arbiter #(
        .numReq      (NUM_REQ),
        .timeoutClks (16)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_data    (i_data),
        .o_grant   (o_grant),
        .o_txStart (o_txStart),
        .o_txData  (o_txData),
        .i_txDone  (i_txDone),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] dataTab [NUM_REQ] = '{8'h17, 8'h5C, 8'hA5, 8'hD3};
    int         checkCnt = 0;
    int         passCnt  = 0;
    int         startCnt = 0;
    bit         uartAuto = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checkCnt++;
        if (act === req) passCnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic pushExp(input int idx);
        exp_t e;
        e.idx  = idx;
        e.data = dataTab[idx];
        expQ.push_back(e);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulseDone();
        tick();
        doneManual = 1'b1;
        tick();
        doneManual = 1'b0;
    endtask

    task automatic waitStarts(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            #1;
            if (startCnt >= target) return;
        end
        checkCnt++;
        $display("FAIL %s: saw %0d starts, required %0d within %0d cycles",
                 name, startCnt, target, budget);
    endtask

    task automatic waitIdle(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge i_clk);
            if (!o_busy) return;
        end
        checkCnt++;
        $display("FAIL %s: o_busy still 1, required 0 within %0d cycles", name, budget);
    endtask

    // Scoreboard monitor: every start must match the oldest expected grant.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_txStart) begin
                startCnt++;
                if (expQ.size() == 0) begin
                    checkCnt++;
                    $display("FAIL unexpected_start: o_grant=%b o_txData=0x%h, required no start",
                             o_grant, o_txData);
                end else begin
                    exp_t             e;
                    logic [NUM_REQ-1:0] g;
                    e = expQ.pop_front();
                    g = 4'b0001 << e.idx;
                    $display("grant #%0d: o_grant=%b o_txData=0x%h (required %b / 0x%h)",
                             startCnt, o_grant, o_txData, g, e.data);
                    check("sb_grant", 32'(o_grant), 32'(g));
                    check("sb_txData", 32'(o_txData), 32'(e.data));
                end
            end else if (o_grant != '0) begin
                check("grant_without_start", 32'(o_grant), 32'd0);
            end
        end
    end

    // uart_tx stand-in: done pulse DONE_DLY cycles after each observed start.
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_txStart && uartAuto) begin
                repeat (DONE_DLY) @(posedge i_clk);
                #1 doneAuto = 1'b1;
                @(posedge i_clk);
                #1 doneAuto = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int base;
        i_rst  = 1'b1;
        i_req  = '0;
        i_data = 32'hD3A55C17;
        repeat (3) tick();

        // Reset state
        @(negedge i_clk);
        check("rst_grant",   32'(o_grant),   32'd0);
        check("rst_txStart", 32'(o_txStart), 32'd0);
        check("rst_txData",  32'(o_txData),  32'd0);
        check("rst_busy",    32'(o_busy),    32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);
        tick();
        i_rst = 1'b0;

        // T2: all four requesting, rrPtr starts at 0 -> 0,1,2,3,0,1
        uartAuto = 1'b1;
        pushExp(0); pushExp(1); pushExp(2); pushExp(3); pushExp(0); pushExp(1);
        base  = startCnt;
        i_req = 4'b1111;
        waitStarts(base + 6, 200, "t2_starts");
        tick();
        i_req = '0;
        waitIdle(100, "t2_idle");
        repeat (20) tick();
        check("t2_start_count", 32'(startCnt - base), 32'd6);

        // T1: single requester 2 (rrPtr=2), one-cycle latency, no restart
        uartAuto = 1'b0;
        pushExp(2);
        base  = startCnt;
        i_req = 4'b0100;
        tick();
        @(negedge i_clk);
        check("t1_latency_start", 32'(o_txStart), 32'd1);
        check("t1_latency_grant", 32'(o_grant),   32'b0100);
        tick();
        i_req = '0;
        repeat (20) @(negedge i_clk);
        check("t1_no_second_start", 32'(startCnt - base), 32'd1);
        check("t1_busy_wait",       32'(o_busy),          32'd1);
        pulseDone();
        waitIdle(10, "t1_idle");

        // T4a: done pulse in IDLE is ignored
        base = startCnt;
        tick();
        doneManual = 1'b1;
        tick();
        doneManual = 1'b0;
        repeat (5) @(negedge i_clk);
        check("t4_idle_busy",   32'(o_busy),          32'd0);
        check("t4_idle_starts", 32'(startCnt - base), 32'd0);

        // T4b + T3: grant to 3, done during SEND ignored; then 1001 -> 0, 3
        pushExp(3);
        base = startCnt;
        tick();
        i_req = 4'b1000;
        tick();                 // SEND cycle
        doneManual = 1'b1;
        i_req      = 4'b1001;   // no effect until IDLE
        pushExp(0);
        pushExp(3);
        tick();
        doneManual = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge i_clk);
            check("t4_busy_hold", 32'(o_busy), 32'd1);
        end
        check("t4_single_start", 32'(startCnt - base), 32'd1);
        uartAuto = 1'b1;
        pulseDone();
        waitStarts(base + 3, 200, "t3_starts");
        tick();
        i_req = '0;
        waitIdle(100, "t3_idle");

        // T5: reset during WAIT_DONE, then 0110 -> requester 1
        uartAuto = 1'b0;
        pushExp(0);
        tick();
        i_req = 4'b0001;
        tick();
        tick();
        i_req = '0;
        repeat (3) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        @(negedge i_clk);
        check("t5_grant",   32'(o_grant),   32'd0);
        check("t5_txStart", 32'(o_txStart), 32'd0);
        check("t5_txData",  32'(o_txData),  32'd0);
        check("t5_busy",    32'(o_busy),    32'd0);
        check("t5_timeout", 32'(o_timeout), 32'd0);
        pushExp(1);
        uartAuto = 1'b1;
        base     = startCnt;
        tick();
        i_req = 4'b0110;
        waitStarts(base + 1, 20, "t5_start");
        tick();
        i_req = '0;
        waitIdle(100, "t5_idle");

        // T6: no done at all (rrPtr=2, only requester 0 -> wraps to 0)
        uartAuto = 1'b0;
        pushExp(0);
        tick();
        i_req = 4'b0001;
        tick();
        @(negedge i_clk);
        check("t6_start", 32'(o_txStart), 32'd1);
        tick();
        i_req = '0;
`ifdef UART_ARB_TIMEOUT_EN
        repeat (16) @(negedge i_clk);
        check("t6_timeout_early", 32'(o_timeout), 32'd0);
        check("t6_busy_early",    32'(o_busy),    32'd1);
        @(negedge i_clk);
        check("t6_timeout_pulse", 32'(o_timeout), 32'd1);
        check("t6_busy_dropped",  32'(o_busy),    32'd0);
        @(negedge i_clk);
        check("t6_timeout_end",   32'(o_timeout), 32'd0);
        pushExp(1);
        uartAuto = 1'b1;
        base     = startCnt;
        tick();
        i_req = 4'b0010;
        waitStarts(base + 1, 20, "t6_next_start");
        tick();
        i_req = '0;
        waitIdle(100, "t6_idle");
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            check("t6_no_timeout", 32'(o_timeout), 32'd0);
        end
        check("t6_busy_stuck", 32'(o_busy), 32'd1);
        pulseDone();
        waitIdle(10, "t6_idle");
`endif

        repeat (5) tick();
        check("sb_drained", 32'(expQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
